// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single dcache port between the load unit and the store-buffer drain,
// steering IO stores onto the uncached IO bus. Loads win unless a committed store is forced.
module dcache_port_arbiter #(
  parameter int PHYS         = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            cpu_clk_i,
  input  logic            cpu_rst_i,
  input  logic            flush_i,
  input  logic            ld_req_i,
  input  logic [PHYS-3:0] ld_addr_i,
  output logic            ld_done_o,
  output logic [31:0]     ld_data_o,
  input  logic            st_valid_i,
  input  logic [PHYS-3:0] st_addr_i,
  input  logic [31:0]     st_data_i,
  input  logic [3:0]      st_bm_i,
  input  logic            st_io_i,
  output logic            st_done_o,
  input  logic            sb_full_i,
  input  logic            drain_i,
  output logic            dc_req_o,
  output logic            dc_we_o,
  output logic [PHYS-3:0] dc_addr_o,
  output logic [31:0]     dc_wdata_o,
  output logic [3:0]      dc_bm_o,
  input  logic [31:0]     dc_rdata_i,
  input  logic            dc_ack_i,
  output logic            io_req_o,
  output logic [PHYS-3:0] io_addr_o,
  output logic [31:0]     io_wdata_o,
  output logic [3:0]      io_bm_o,
  input  logic            io_ack_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, IOWR} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          kill;
  logic          force_st, grant_ld, grant_st;

  always_comb begin
    state_nxt = state;
    grant_ld  = 1'b0;
    grant_st  = 1'b0;
    force_st  = st_valid_i && ((cnt >= LIMIT) || sb_full_i || drain_i);
    case (state)
      IDLE: begin
        if (force_st)                  grant_st = 1'b1;
        else if (ld_req_i && !flush_i) grant_ld = 1'b1;
        else if (st_valid_i)           grant_st = 1'b1;
        if (grant_st)      state_nxt = st_io_i ? IOWR : STORE;
        else if (grant_ld) state_nxt = LOAD;
      end
      LOAD, STORE: if (dc_ack_i) state_nxt = IDLE;
      IOWR:        if (io_ack_i) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase

    // Starvation only accrues while a store is actually losing the port to loads.
    cnt_nxt = cnt;
    if (grant_st || !st_valid_i)
      cnt_nxt = '0;
    else if ((state == IDLE || state == LOAD) && cnt != LIMIT)
      cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      kill       <= 1'b0;
      dc_req_o   <= 1'b0;
      dc_we_o    <= 1'b0;
      dc_addr_o  <= '0;
      dc_wdata_o <= '0;
      dc_bm_o    <= '0;
      io_req_o   <= 1'b0;
      io_addr_o  <= '0;
      io_wdata_o <= '0;
      io_bm_o    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dc_req_o <= (state_nxt == LOAD) || (state_nxt == STORE);
      io_req_o <= (state_nxt == IOWR);
      // A flush seen any cycle of the load kills its completion, even if the ack comes later.
      if (grant_ld)
        kill <= 1'b0;
      else if (state == LOAD && flush_i)
        kill <= 1'b1;
      if (grant_ld) begin
        dc_we_o    <= 1'b0;
        dc_addr_o  <= ld_addr_i;
        dc_wdata_o <= '0;
        dc_bm_o    <= 4'hF;
      end else if (grant_st && !st_io_i) begin
        dc_we_o    <= 1'b1;
        dc_addr_o  <= st_addr_i;
        dc_wdata_o <= st_data_i;
        dc_bm_o    <= st_bm_i;
      end else if (grant_st) begin
        io_addr_o  <= st_addr_i;
        io_wdata_o <= st_data_i;
        io_bm_o    <= st_bm_i;
      end
    end
  end

  assign ld_done_o = dc_ack_i && (state == LOAD) && !flush_i && !kill;
  assign ld_data_o = ld_done_o ? dc_rdata_i : 32'h0;
  assign st_done_o = (dc_ack_i && state == STORE) || (io_ack_i && state == IOWR);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed scenarios followed by random traffic, all checked
// cycle by cycle against a transaction-level model of the port owner.
module tb_dcache_port_arbiter;
  localparam int PHYS  = 32;
  localparam int LIMIT = 8;
  localparam int AW    = PHYS - 2;

  logic          clk = 1'b0;
  logic          rst, flush, ld_req, st_valid, st_io, sb_full, drain, dc_ack, io_ack;
  logic [AW-1:0] ld_addr, st_addr;
  logic [31:0]   st_data, dc_rdata;
  logic [3:0]    st_bm;
  logic          ld_done, st_done, dc_req, dc_we, io_req;
  logic [31:0]   ld_data, dc_wdata, io_wdata;
  logic [AW-1:0] dc_addr, io_addr;
  logic [3:0]    dc_bm, io_bm;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.PHYS(PHYS), .STARVE_LIMIT(LIMIT)) dut (
    .cpu_clk_i(clk), .cpu_rst_i(rst), .flush_i(flush),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_done_o(ld_done), .ld_data_o(ld_data),
    .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_bm_i(st_bm),
    .st_io_i(st_io), .st_done_o(st_done), .sb_full_i(sb_full), .drain_i(drain),
    .dc_req_o(dc_req), .dc_we_o(dc_we), .dc_addr_o(dc_addr), .dc_wdata_o(dc_wdata),
    .dc_bm_o(dc_bm), .dc_rdata_i(dc_rdata), .dc_ack_i(dc_ack),
    .io_req_o(io_req), .io_addr_o(io_addr), .io_wdata_o(io_wdata), .io_bm_o(io_bm),
    .io_ack_i(io_ack)
  );

  int tests = 0;
  int fails = 0;

  // Model: who owns the port (none / load / store / io), what was latched, and how long a store has waited.
  bit            m_busy;
  int            m_kind;  // 0 load, 1 cached store, 2 io store
  int            m_starve;
  bit            m_kill;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_bm;

  logic          c_ld_done, c_st_done, c_dc_req, c_io_req, c_dc_we;
  logic [31:0]   c_ld_data, c_io_wdata;
  logic [AW-1:0] c_dc_addr, c_io_addr;
  logic [3:0]    c_io_bm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic e_dcr, e_ior, e_ldd, e_std, counts, gst, frc, ld_ok;
    #1;
    e_dcr = m_busy && m_kind != 2;
    e_ior = m_busy && m_kind == 2;
    e_ldd = m_busy && m_kind == 0 && dc_ack && !flush && !m_kill;
    e_std = m_busy && ((m_kind == 1 && dc_ack) || (m_kind == 2 && io_ack));
    chk("dc_req", dc_req, e_dcr);
    chk("io_req", io_req, e_ior);
    chk("ld_done", ld_done, e_ldd);
    chk("st_done", st_done, e_std);
    chk("ld_data", ld_data, e_ldd ? dc_rdata : 32'h0);
    if (e_dcr) begin
      chk("dc_we", dc_we, m_kind == 1);
      chk("dc_addr", dc_addr, m_addr);
      chk("dc_bm", dc_bm, m_bm);
      if (m_kind == 1) chk("dc_wdata", dc_wdata, m_wdata);
    end
    if (e_ior) begin
      chk("io_addr", io_addr, m_addr);
      chk("io_wdata", io_wdata, m_wdata);
      chk("io_bm", io_bm, m_bm);
    end
    c_ld_done = ld_done;  c_st_done = st_done;  c_dc_req = dc_req;  c_io_req = io_req;
    c_dc_we = dc_we;      c_ld_data = ld_data;  c_dc_addr = dc_addr;
    c_io_addr = io_addr;  c_io_wdata = io_wdata; c_io_bm = io_bm;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_starve = 0; m_kill = 0;
    end else begin
      counts = !m_busy || m_kind == 0;
      gst    = 0;
      if (m_busy) begin
        if (m_kind == 0 && flush) m_kill = 1;
        if ((m_kind == 2 && io_ack) || (m_kind != 2 && dc_ack)) m_busy = 0;
      end else begin
        frc   = st_valid && (m_starve >= LIMIT || sb_full || drain);
        ld_ok = ld_req && !flush;
        if (frc || (st_valid && !ld_ok)) begin
          gst = 1; m_busy = 1; m_kind = st_io ? 2 : 1;
          m_addr = st_addr; m_wdata = st_data; m_bm = st_bm;
        end else if (ld_ok) begin
          m_busy = 1; m_kind = 0; m_addr = ld_addr; m_bm = 4'hF; m_kill = 0;
        end
      end
      if (gst || !st_valid) m_starve = 0;
      else if (counts && m_starve < LIMIT) m_starve++;
    end
    @(negedge clk);
  endtask

  task automatic new_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] bm, input logic io);
    st_valid = 1; st_addr = a; st_data = d; st_bm = bm; st_io = io;
  endtask

  initial begin
    int loads;
    bit done, prev_flush;
    rst = 1; flush = 0; ld_req = 0; ld_addr = '0; st_valid = 0; st_addr = '0; st_data = '0;
    st_bm = '0; st_io = 0; sb_full = 0; drain = 0; dc_ack = 0; io_ack = 0; dc_rdata = '0;
    m_busy = 0; m_kind = 0; m_starve = 0; m_kill = 0; m_addr = '0; m_wdata = '0; m_bm = '0;
    @(negedge clk);
    step(); step();
    chk("rst_dc_req", c_dc_req, 0);
    chk("rst_io_req", c_io_req, 0);
    chk("rst_dc_addr", c_dc_addr, 0);
    chk("rst_io_wdata", c_io_wdata, 0);
    rst = 0;

    // Plain load, ack two cycles after the request appears.
    ld_req = 1; ld_addr = 30'h123;
    step();
    step(); chk("t1_req", c_dc_req, 1); chk("t1_we", c_dc_we, 0);
    step();
    dc_ack = 1; dc_rdata = 32'hCAFE0001;
    step(); chk("t1_done", c_ld_done, 1); chk("t1_data", c_ld_data, 32'hCAFE0001);
    dc_ack = 0; ld_req = 0;
    step(); chk("t1_idle", c_dc_req, 0);

    // IO store goes only to the IO bus.
    new_store(30'h400, 32'hDEADBEEF, 4'b0011, 1);
    step();
    step(); chk("t3_io_req", c_io_req, 1); chk("t3_dc_req", c_dc_req, 0);
    chk("t3_addr", c_io_addr, 30'h400); chk("t3_data", c_io_wdata, 32'hDEADBEEF); chk("t3_bm", c_io_bm, 4'b0011);
    io_ack = 1;
    step(); chk("t3_done", c_st_done, 1);
    io_ack = 0; st_valid = 0; st_io = 0;
    step();

    // Flush one cycle before the load ack suppresses the completion; the waiting store then goes.
    ld_req = 1; ld_addr = 30'h55;
    step(); step();
    flush = 1; step();
    flush = 0; ld_req = 0; new_store(30'h77, 32'h1234_5678, 4'hF, 0); dc_ack = 1;
    step(); chk("t4_no_done", c_ld_done, 0);
    dc_ack = 0;
    step();
    step(); chk("t4_st_req", c_dc_req, 1); chk("t4_st_we", c_dc_we, 1); chk("t4_st_addr", c_dc_addr, 30'h77);
    dc_ack = 1;
    step(); chk("t4_st_done", c_st_done, 1);
    dc_ack = 0; st_valid = 0;
    step();

    // Full store buffer, then drain, each beat a competing load.
    sb_full = 1; ld_req = 1; ld_addr = 30'h66; new_store(30'h88, 32'hA5A5_0088, 4'b1100, 0);
    step();
    step(); chk("t5_full_we", c_dc_we, 1); chk("t5_full_addr", c_dc_addr, 30'h88);
    dc_ack = 1; step(); chk("t5_full_done", c_st_done, 1);
    st_valid = 0; sb_full = 0; dc_ack = 0;
    step(); step();
    dc_ack = 1; step(); chk("t5_ld_done", c_ld_done, 1);
    dc_ack = 0; drain = 1; ld_addr = 30'h67; new_store(30'h99, 32'h0BAD_F00D, 4'b0101, 0);
    step();
    step(); chk("t5_drain_we", c_dc_we, 1); chk("t5_drain_addr", c_dc_addr, 30'h99);
    dc_ack = 1; step(); chk("t5_drain_done", c_st_done, 1);
    st_valid = 0; drain = 0; ld_req = 0; dc_ack = 0;
    step();

    // Reset in the middle of a store; a late ack must be ignored.
    new_store(30'hAA, 32'h0000_00AA, 4'hF, 0);
    step();
    step(); chk("t6_req", c_dc_req, 1);
    rst = 1; step();
    rst = 0; dc_ack = 1;
    step(); chk("t6_req_drop", c_dc_req, 0); chk("t6_no_done", c_st_done, 0);
    dc_ack = 0; step();
    dc_ack = 1; step(); chk("t6_reissue_done", c_st_done, 1);
    dc_ack = 0; st_valid = 0;
    step();

    // Loads held continuously with instant acks: the store waits (LIMIT+1)/2 two-cycle loads.
    ld_req = 1; ld_addr = 30'h200; new_store(30'hBB, 32'h5EED_00BB, 4'b1001, 0);
    loads = 0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      dc_ack = m_busy && m_kind != 2;
      step();
      if (c_ld_done) begin loads++; ld_addr = ld_addr + 1'b1; end
      if (c_st_done) done = 1;
    end
    chk("t2_store_done", done, 1);
    chk("t2_loads_before", loads, (LIMIT + 1) / 2);
    ld_req = 0; st_valid = 0; dc_ack = 0;
    step();

    // Random traffic.
    prev_flush = 0;
    for (int i = 0; i < 3000; i++) begin
      if (c_ld_done || prev_flush) ld_req = 0;
      if (c_st_done) st_valid = 0;
      rst     = ($urandom % 150) == 0;
      flush   = ($urandom % 10) == 0;
      sb_full = ($urandom % 10) == 0;
      drain   = ($urandom % 12) == 0;
      if (!ld_req && ($urandom % 2) == 0) begin ld_req = 1; ld_addr = 30'($urandom); end
      if (!st_valid && ($urandom % 3) == 0)
        new_store(30'($urandom), $urandom, 4'($urandom), ($urandom % 4) == 0);
      dc_ack   = (m_busy && m_kind != 2) ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
      io_ack   = (m_busy && m_kind == 2) ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
      dc_rdata = $urandom;
      prev_flush = flush;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
